// File: rtl/sha256_w_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_w_sched (with helper sha256_w_sched_ror)
//  Description : SHA-256 message-schedule sequencer. Accepts the 16 words of
//                one 512-bit block on a valid/ready stream, forwards them as
//                W[0..15], then expands W[16..ROUNDS-1] in place in a 16-entry
//                circular buffer. Emits one W word per output handshake.
//  Ports       : clk, rst_n (sync, active-low)
//                start                  - begin a block (sampled in IDLE)
//                in_valid/in_ready/in_word    - message word stream
//                out_valid/out_ready/out_word/out_idx - schedule word stream
//                busy                   - not IDLE
//                done                   - 1-cycle pulse after last W accepted
//  Revision    : 1.0 - initial release
// ============================================================================

// Fixed-amount 32-bit rotate right.
module sha256_w_sched_ror #(
    parameter int N = 7
) (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    assign o_y = (i_x >> N) | (i_x << (32 - N));
endmodule

module sha256_w_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    if (ROUNDS < 17 || ROUNDS > 64) begin : g_rounds_check
        $error("sha256_w_sched: ROUNDS must be in 17..64");
    end

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_GEN   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam logic [6:0] c_LAST_LOAD = 7'd15;
    localparam logic [6:0] c_LAST_T    = 7'(ROUNDS - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_t;
    logic [31:0] r_buf [16];
    logic        r_out_valid;
    logic [31:0] r_out_word;
    logic [5:0]  r_out_idx;
    logic        r_done;

    logic        w_adv;
    logic        w_in_fire;
    logic        w_gen_fire;
    logic        w_buf_we;
    logic [31:0] w_buf_wdata;
    logic [3:0]  w_i0;
    logic [3:0]  w_i2;
    logic [3:0]  w_i7;
    logic [3:0]  w_i15;
    logic [31:0] w_x2;
    logic [31:0] w_x15;
    logic [31:0] w_r7;
    logic [31:0] w_r18;
    logic [31:0] w_r17;
    logic [31:0] w_r19;
    logic [31:0] w_sig0;
    logic [31:0] w_sig1;
    logic [31:0] w_next;

    // The output register may be refilled whenever it is empty or being drained.
    assign w_adv      = !r_out_valid || out_ready;
    assign in_ready   = (r_state == c_LOAD) && w_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_gen_fire = (r_state == c_GEN) && w_adv;

    // 4-bit index arithmetic gives the modulo-16 wrap of the circular buffer.
    // Slot t&15 still holds W[t-16] until it is overwritten by W[t].
    assign w_i0  = r_t[3:0];
    assign w_i2  = r_t[3:0] - 4'd2;
    assign w_i7  = r_t[3:0] - 4'd7;
    assign w_i15 = r_t[3:0] - 4'd15;

    assign w_x2  = r_buf[w_i2];
    assign w_x15 = r_buf[w_i15];

    sha256_w_sched_ror #(.N(7))  u_ror7  (.i_x(w_x15), .o_y(w_r7));
    sha256_w_sched_ror #(.N(18)) u_ror18 (.i_x(w_x15), .o_y(w_r18));
    sha256_w_sched_ror #(.N(17)) u_ror17 (.i_x(w_x2),  .o_y(w_r17));
    sha256_w_sched_ror #(.N(19)) u_ror19 (.i_x(w_x2),  .o_y(w_r19));

    assign w_sig0 = w_r7  ^ w_r18 ^ (w_x15 >> 3);
    assign w_sig1 = w_r17 ^ w_r19 ^ (w_x2 >> 10);
    assign w_next = w_sig1 + r_buf[w_i7] + w_sig0 + r_buf[w_i0];

    assign w_buf_we    = ((r_state == c_LOAD) && w_in_fire) || w_gen_fire;
    assign w_buf_wdata = (r_state == c_LOAD) ? in_word : w_next;

    // Buffer storage carries no reset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (rst_n && w_buf_we) begin
            r_buf[w_i0] <= w_buf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_t         <= 7'd0;
            r_out_valid <= 1'b0;
            r_out_word  <= 32'd0;
            r_out_idx   <= 6'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A consumed word empties the slot unless it is refilled below.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_LOAD;
                        r_t     <= 7'd0;
                    end
                end
                c_LOAD: begin
                    if (w_in_fire) begin
                        r_out_word  <= in_word;
                        r_out_idx   <= r_t[5:0];
                        r_out_valid <= 1'b1;
                        r_t         <= r_t + 7'd1;
                        if (r_t == c_LAST_LOAD) begin
                            r_state <= c_GEN;
                        end
                    end
                end
                c_GEN: begin
                    if (w_adv) begin
                        r_out_word  <= w_next;
                        r_out_idx   <= r_t[5:0];
                        r_out_valid <= 1'b1;
                        r_t         <= r_t + 7'd1;
                        if (r_t == c_LAST_T) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_idx   = r_out_idx;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha256_w_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_w_sched
//  Description : Self-checking bench for sha256_w_sched. A plain-array model
//                of the SHA-256 schedule supplies expected W values; one
//                compare process checks every output handshake, stall
//                stability, input handshake count and done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_w_sched;

    localparam int ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start17 = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = 32'd0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        in_ready17, out_valid17, busy17, done17;
    logic [31:0] out_word17;
    logic [5:0]  out_idx17;

    always #5 clk = ~clk;

    sha256_w_sched #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_word(in_word), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    sha256_w_sched #(.ROUNDS(17)) dut17 (
        .clk(clk), .rst_n(rst_n), .start(start17), .in_valid(in_valid),
        .in_ready(in_ready17), .in_word(in_word), .out_valid(out_valid17),
        .out_ready(out_ready), .out_word(out_word17), .out_idx(out_idx17),
        .busy(busy17), .done(done17)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired, event not seen", nm);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] blk_abc [16];
    logic [31:0] blk_two [16];
    logic [31:0] cur_blk [16];
    logic [31:0] exp_w   [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model();
        for (int i = 0; i < 16; i++) exp_w[i] = cur_blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // ---------------- output ready driver ----------------
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- compare process ----------------
    int          exp_idx = 0;
    int          in_cnt = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_in_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;
    bit          prev_busy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word;
    logic [5:0]  prev_idx;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_busy  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                exp_idx = 0;
                in_cnt  = 0;
            end
            if (!busy) chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_word", out_word, prev_word);
                chk("stall_idx", {26'd0, out_idx}, {26'd0, prev_idx});
            end
            if (in_valid && in_ready) begin
                if (in_cnt == 0) first_in_cyc = cyc;
                in_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_idx >= ROUNDS) begin
                    chk("extra_word_idx", {26'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    if (exp_idx == 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                    chk($sformatf("idx_t%0d", exp_idx), {26'd0, out_idx}, 32'(exp_idx));
                    chk($sformatf("word_t%0d", exp_idx), out_word, exp_w[exp_idx]);
                    exp_idx++;
                end
            end
            if (done) begin
                chk("done_word_count", 32'(exp_idx), 32'(ROUNDS));
                chk("done_in_count", 32'(in_cnt), 32'd16);
                done_cnt++;
            end
            prev_busy  = busy;
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
            prev_idx   = out_idx;
        end
    end

    // ---------------- ROUNDS=17 instance monitor ----------------
    int          cnt17 = 0, dcnt17 = 0;
    logic [31:0] last_word17 = 32'd0;
    logic [5:0]  last_idx17 = 6'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid17 && out_ready) begin
                cnt17++;
                last_word17 = out_word17;
                last_idx17  = out_idx17;
            end
            if (done17) dcnt17++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int gap_pct, input bit noise);
        int  i;
        int  c;
        bit  hs;
        i = 0;
        c = 0;
        while (i < 16 && c < 2000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_word  = in_valid ? cur_blk[i] : 32'hDEAD_BEEF;
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = in_valid && in_ready;
            tick();
            if (hs) i++;
            c++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < 16) fail("feed_timeout");
    endtask

    task automatic wait_done(input bit noise, input bit b2b);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            if (noise && out_valid && out_idx < 6'd56) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word  = $urandom;
                start    = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
                start    = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
            else tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!seen) fail("done_timeout");
        if (seen && b2b) begin
            cur_blk = blk_two;
            build_model();
            start = 1'b1;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic start_block();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        for (int i = 0; i < 16; i++) begin
            blk_abc[i] = 32'd0;
            blk_two[i] = 32'h0123_4567 + 32'(i) * 32'h1111_1111;
        end
        blk_abc[0]  = 32'h6162_6380;
        blk_abc[15] = 32'h0000_0018;

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_idx", {26'd0, out_idx}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // model pinned against hand-computed "abc" values
        cur_blk = blk_abc;
        build_model();
        chk("model_w16", exp_w[16], 32'h6162_6380);
        chk("model_w17", exp_w[17], 32'h000F_0000);

        // 1: "abc" block, continuous ready, plus ROUNDS=17 instance
        rand_ready = 1'b0;
        start   = 1'b1;
        start17 = 1'b1;
        tick();
        start   = 1'b0;
        start17 = 1'b0;
        feed(0, 1'b0);
        wait_done(1'b0, 1'b0);
        chk("latency_first_out", 32'(first_out_cyc - first_in_cyc), 32'd1);
        chk("span_64_handshakes", 32'(last_out_cyc - first_out_cyc), 32'd63);
        chk("done_cnt_blk1", 32'(done_cnt), 32'd1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("r17_word_count", 32'(cnt17), 32'd17);
        chk("r17_last_idx", {26'd0, last_idx17}, 32'd16);
        chk("r17_last_word", last_word17, 32'h6162_6380);
        chk("r17_done_cnt", 32'(dcnt17), 32'd1);

        // 2: random stalls, input gaps, stray start/in_valid during LOAD/GEN
        rand_ready = 1'b1;
        start_block();
        feed(35, 1'b1);
        wait_done(1'b1, 1'b0);
        rand_ready = 1'b0;
        chk("done_cnt_blk2", 32'(done_cnt), 32'd2);
        repeat (3) tick();
        chk("idle_after_noise", {31'd0, busy}, 32'd0);

        // 3: reset mid-GEN abandons the block
        start_block();
        feed(0, 1'b0);
        d0 = done_cnt;
        begin
            bit found;
            found = 1'b0;
            for (int c = 0; c < 200 && !found; c++) begin
                @(negedge clk);
                if (out_valid && out_idx == 6'd30) found = 1'b1;
                tick();
            end
            if (!found) fail("reach_t30_timeout");
        end
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        start_block();
        feed(0, 1'b0);
        wait_done(1'b0, 1'b0);
        chk("done_cnt_after_rst", 32'(done_cnt), 32'(d0 + 1));

        // 4: back-to-back blocks, second start while done is high
        start_block();
        feed(0, 1'b0);
        wait_done(1'b0, 1'b1);
        feed(0, 1'b0);
        wait_done(1'b0, 1'b0);
        chk("done_cnt_b2b", 32'(done_cnt), 32'(d0 + 3));
        chk("b2b_model_w0", exp_w[0], 32'h0123_4567);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
